// File: rtl/kernel_seq_pkg.sv
// Shared types and default widths for the kernel memory sequencer.
package kernel_seq_pkg;

  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 50;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_READ    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/kernel_mem_sequencer.sv
// Preloads a word memory from a stream, runs an HLS kernel under a watchdog,
// then reads back one result word.
module kernel_mem_sequencer
  import kernel_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [ADDR_W-1:0] result_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              kernel_rst,
  input  logic              kernel_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [DATA_W-1:0] result,
  output logic [31:0]       state_dbg
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

  seq_state_e        state, state_nx;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  wcount;
  logic [ADDR_W-1:0] raddr_q;
  logic [TMR_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  clamped_c;
  logic              take_start_c;
  logic              timeout_hit_c;

  assign clamped_c = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state and combinational stream/memory handshake
  always_comb begin
    state_nx      = state;
    in_ready      = 1'b0;
    mem_wen       = 1'b0;
    take_start_c  = 1'b0;
    timeout_hit_c = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          take_start_c = 1'b1;
          state_nx     = (clamped_c != '0) ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_wen = 1'b1;
          if (wcount == word_cnt - CNT_W'(1)) state_nx = S_RUN;
        end
      end
      S_RUN: begin
        // kernel_valid wins over a coincident timeout
        if (kernel_valid) begin
          state_nx = S_READ;
        end else if (run_cnt == TMR_W'(TIMEOUT - 1)) begin
          timeout_hit_c = 1'b1;
          state_nx      = S_DONE;
        end
      end
      S_READ:    state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_DONE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Job parameters, counters and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt    <= '0;
      wcount      <= '0;
      raddr_q     <= '0;
      run_cnt     <= '0;
      timeout_err <= 1'b0;
      result      <= '0;
    end else begin
      if (take_start_c) begin
        word_cnt    <= clamped_c;
        raddr_q     <= result_addr;
        wcount      <= '0;
        timeout_err <= 1'b0;
      end
      if (mem_wen) wcount <= wcount + CNT_W'(1);
      // Held at zero outside RUN so it starts cleared on entry
      if (state == S_RUN) run_cnt <= run_cnt + TMR_W'(1);
      else                run_cnt <= '0;
      if (timeout_hit_c) begin
        timeout_err <= 1'b1;
        result      <= '0;
      end
      if (state == S_CAPTURE) result <= mem_rdata;
    end
  end

  assign mem_waddr  = wcount[ADDR_W-1:0];
  assign mem_wdata  = in_data;
  assign mem_raddr  = raddr_q;
  assign kernel_rst = (state != S_RUN);
  assign busy       = (state == S_LOAD) || (state == S_RUN) ||
                      (state == S_READ) || (state == S_CAPTURE);
  assign done       = (state == S_DONE);
  assign state_dbg  = 32'(state);

endmodule

// File: tb/tb_kernel_mem_sequencer.sv
// Directed bench for kernel_mem_sequencer with memory and kernel models.
module tb_kernel_mem_sequencer;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [AW-1:0] result_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          kernel_rst;
  logic          kernel_valid;
  logic          busy, done, timeout_err;
  logic [DW-1:0] result;
  logic [31:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  kernel_mem_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .result_addr(result_addr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .kernel_rst(kernel_rst), .kernel_valid(kernel_valid), .busy(busy),
    .done(done), .timeout_err(timeout_err), .result(result),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Memory model with 1-cycle read latency plus a log of write addresses
  logic [DW-1:0] mem [0:31];
  int            wlog [0:255];
  int            wcnt = 0;
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_waddr] <= mem_wdata;
      wlog[wcnt]     <= int'(mem_waddr);
      wcnt           <= wcnt + 1;
    end
    mem_rdata <= mem[mem_raddr];
  end

  // Kernel model: valid 20 cycles after kernel_rst falls, when enabled
  bit kv_en = 1'b1;
  int kcnt  = 0;
  always @(posedge clk) begin
    if (kernel_rst) kcnt <= 0;
    else            kcnt <= kcnt + 1;
  end
  assign kernel_valid = kv_en && !kernel_rst && (kcnt == 20);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok, output int runs);
    ok   = 1'b0;
    runs = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (state_dbg == 32'd2) runs++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_checks++; if (state_dbg !== 32'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    n_checks++; if (kernel_rst !== 1'b1) begin n_fail++; $display("FAIL reset_kernel_rst got=%b exp=1", kernel_rst); end
    n_checks++; if ({in_ready, mem_wen, busy, done, timeout_err} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, mem_wen, busy, done, timeout_err}); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    bit ok; int runs; int base;
    base = wcnt;
    kv_en = 1'b1;
    start = 1'b1; num_words = 6'd16; result_addr = 5'd10;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_enter_load busy=%b in_ready=%b exp=1,1", busy, in_ready); end
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = DW'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    wait_done(200, ok, runs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_done_timeout done=%b exp=1", done); end
    n_checks++; if (runs !== 21) begin n_fail++; $display("FAIL full_run_cycles got=%0d exp=21", runs); end
    n_checks++; if (wcnt - base !== 16) begin n_fail++; $display("FAIL full_write_count got=%0d exp=16", wcnt - base); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (mem[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL full_mem[%0d] got=%h exp=%h", i, mem[i], i + 1); end
    end
    n_checks++; if (result !== 32'd11) begin n_fail++; $display("FAIL full_result got=%h exp=0000000b", result); end
    n_checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_status timeout_err=%b busy=%b exp=0,0", timeout_err, busy); end
  endtask

  task automatic test_stall();
    bit ok; int runs; int base; int k;
    base = wcnt;
    start = 1'b1; num_words = 6'd4; result_addr = 5'd2;
    tick();
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = 32'hA0 + DW'(k);
      tick();
      if (in_valid) k++;
    end
    in_valid = 1'b0;
    wait_done(200, ok, runs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_done_timeout done=%b exp=1", done); end
    n_checks++; if (wcnt - base !== 4) begin n_fail++; $display("FAIL stall_write_count got=%0d exp=4", wcnt - base); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (wlog[base + i] !== i) begin n_fail++; $display("FAIL stall_addr[%0d] got=%0d exp=%0d", i, wlog[base + i], i); end
      n_checks++; if (mem[i] !== 32'hA0 + DW'(i)) begin n_fail++; $display("FAIL stall_mem[%0d] got=%h exp=%h", i, mem[i], 32'hA0 + i); end
    end
    n_checks++; if (result !== 32'hA2) begin n_fail++; $display("FAIL stall_result got=%h exp=000000a2", result); end
  endtask

  task automatic test_timeout();
    bit ok; int runs;
    kv_en = 1'b0;
    start = 1'b1; num_words = 6'd0; result_addr = 5'd3;
    tick();
    start = 1'b0;
    wait_done(300, ok, runs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_done_timeout done=%b exp=1", done); end
    n_checks++; if (runs !== 50) begin n_fail++; $display("FAIL tmo_run_cycles got=%0d exp=50", runs); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL tmo_result got=%h exp=0", result); end
    n_checks++; if (kernel_rst !== 1'b1 || state_dbg !== 32'd5) begin n_fail++; $display("FAIL tmo_state kernel_rst=%b state=%0d exp=1,5", kernel_rst, state_dbg); end
    // A start from DONE clears done and timeout_err
    kv_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_from_done done=%b timeout_err=%b busy=%b exp=0,0,1", done, timeout_err, busy); end
    wait_done(200, ok, runs);
    n_checks++; if (!ok || timeout_err !== 1'b0) begin n_fail++; $display("FAIL restart_finish done=%b timeout_err=%b exp=1,0", done, timeout_err); end
  endtask

  task automatic test_reset_mid();
    bit ok; int runs; int base;
    start = 1'b1; num_words = 6'd8; result_addr = 5'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hB0 + DW'(i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (state_dbg !== 32'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_state state=%0d in_ready=%b exp=0,0", state_dbg, in_ready); end
    n_checks++; if (kernel_rst !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_flags kernel_rst=%b busy=%b exp=1,0", kernel_rst, busy); end
    n_checks++; if (mem[2] !== 32'hB2) begin n_fail++; $display("FAIL midrst_kept_mem got=%h exp=000000b2", mem[2]); end
    tick();
    rst = 1'b1;
    tick();
    base = wcnt;
    start = 1'b1; num_words = 6'd2; result_addr = 5'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'hC0 + DW'(i);
      tick();
    end
    in_valid = 1'b0;
    wait_done(200, ok, runs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL reload_done_timeout done=%b exp=1", done); end
    n_checks++; if (wcnt - base !== 2 || wlog[base] !== 0) begin n_fail++; $display("FAIL reload_addr count=%0d first=%0d exp=2,0", wcnt - base, wlog[base]); end
    n_checks++; if (result !== 32'hC0 || mem[2] !== 32'hB2) begin n_fail++; $display("FAIL reload_data result=%h mem2=%h exp=c0,b2", result, mem[2]); end
  endtask

  task automatic test_zero_words();
    bit ok; int runs; int base;
    base = wcnt;
    start = 1'b1; num_words = 6'd0; result_addr = 5'd1;
    tick();
    n_checks++; if (state_dbg !== 32'd2 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL zero_direct_run state=%0d mem_wen=%b exp=2,0", state_dbg, mem_wen); end
    tick();
    num_words = 6'd5; result_addr = 5'd7;
    tick();
    start = 1'b0;
    n_checks++; if (state_dbg !== 32'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_busy_start state=%0d in_ready=%b exp=2,0", state_dbg, in_ready); end
    wait_done(200, ok, runs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_done_timeout done=%b exp=1", done); end
    n_checks++; if (wcnt !== base) begin n_fail++; $display("FAIL zero_no_writes got=%0d exp=0", wcnt - base); end
    n_checks++; if (mem_raddr !== 5'd1 || result !== 32'hC1) begin n_fail++; $display("FAIL zero_result raddr=%0d result=%h exp=1,c1", mem_raddr, result); end
  endtask

  task automatic test_clamp();
    bit ok; int runs; int base; int k;
    base = wcnt;
    start = 1'b1; num_words = 6'd63; result_addr = 5'd31;
    tick();
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      if (state_dbg != 32'd1) break;
      in_valid = 1'b1; in_data = 32'h100 + DW'(k);
      tick();
      k++;
    end
    in_valid = 1'b0;
    n_checks++; if (k !== 32) begin n_fail++; $display("FAIL clamp_words got=%0d exp=32", k); end
    wait_done(200, ok, runs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_done_timeout done=%b exp=1", done); end
    n_checks++; if (wcnt - base !== 32 || wlog[base + 31] !== 31) begin n_fail++; $display("FAIL clamp_writes count=%0d last=%0d exp=32,31", wcnt - base, wlog[base + 31]); end
    n_checks++; if (result !== 32'h11F) begin n_fail++; $display("FAIL clamp_result got=%h exp=0000011f", result); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_zero_words();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kernel_mem_sequencer.md
KERNEL_MEM_SEQUENCER -- requirements
Module: kernel_mem_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: memory address width.
REQ-002 SHALL have parameter DATA_W, default 32: memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 50: maximum kernel run cycles.
REQ-004 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1: one-cycle request to begin a load/run/readback job.
REQ-007 SHALL have port num_words  in  ADDR_W+1: number of words to preload.
REQ-008 SHALL have port result_addr  in  ADDR_W: address to read back after the kernel finishes.
REQ-009 SHALL have ports in_valid (in, 1), in_ready (out, 1) and in_data (in, DATA_W): preload stream.
REQ-010 SHALL have ports mem_waddr (out, ADDR_W), mem_wdata (out, DATA_W) and mem_wen (out, 1): memory write port.
REQ-011 SHALL have ports mem_raddr (out, ADDR_W) and mem_rdata (in, DATA_W): memory read port with 1-cycle read latency.
REQ-012 SHALL have port kernel_rst  out  1: active-high reset driven to the HLS kernel.
REQ-013 SHALL have port kernel_valid  in  1: kernel completion flag.
REQ-014 SHALL have ports busy (out, 1), done (out, 1), timeout_err (out, 1) and result (out, DATA_W): job status and read-back value.
REQ-015 SHALL have port state_dbg  out  32: current state encoding, zero-extended.

Function
REQ-016 SHALL implement the states IDLE, LOAD, RUN, READ, CAPTURE and DONE.
REQ-017 IDLE transitions: on start, latch num_words, clamped to 2**ADDR_W, and result_addr; go to LOAD if the latched count is nonzero, otherwise go to RUN.
REQ-018 LOAD: in_ready=1; on each in_valid&&in_ready cycle, mem_wen=1, mem_waddr=wcount and mem_wdata=in_data are driven combinationally in that cycle; wcount then increments.
REQ-019 LOAD: the handshake that writes the last word moves the FSM to RUN on the next edge; mem_wen=0 in every other cycle.
REQ-020 kernel_rst SHALL be 1 in all states except RUN; in RUN it SHALL be 0.
REQ-021 RUN: a cycle counter is cleared on entry and increments each cycle; kernel_valid=1 moves the FSM to READ.
REQ-022 RUN: if the counter reaches TIMEOUT without kernel_valid, the FSM SHALL go to DONE with timeout_err=1 and result=0.
REQ-023 kernel_valid takes priority over the timeout when both occur in the same cycle.
REQ-024 READ: mem_raddr=result_addr; the FSM moves to CAPTURE unconditionally.
REQ-025 CAPTURE: result<=mem_rdata; the FSM moves to DONE.
REQ-026 DONE: done=1, held until the next start; start in DONE clears done and timeout_err and behaves as in IDLE.
REQ-027 busy SHALL be 1 in LOAD, RUN, READ and CAPTURE.
REQ-028 start while busy SHALL be ignored.
REQ-029 in_ready SHALL be 0 outside LOAD.
REQ-030 mem_raddr SHALL hold result_addr in all states.

Reset
REQ-031 rst low SHALL immediately force: state=IDLE, kernel_rst=1, mem_wen=0, in_ready=0, busy=0, done=0, timeout_err=0, result=0, and all counters=0.
REQ-032 Reset mid-job SHALL abandon the job; memory contents already written are not rolled back.

Structure
REQ-033 The state enum and the default widths SHALL live in the shared package kernel_seq_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the counters are inline.

Verification
REQ-035 Load 16 words 1..16, result_addr=10, kernel model asserts kernel_valid 20 cycles after kernel_rst falls -> memory holds 1..16 at addresses 0..15, result=11, done=1, timeout_err=0.
REQ-036 in_valid toggled every other cycle during a 4-word load -> exactly 4 writes to contiguous addresses 0..3, no gaps or duplicates.
REQ-037 kernel_valid never asserted -> DONE entered after exactly 50 RUN cycles, timeout_err=1, result=0, kernel_rst=1.
REQ-038 rst pulsed low after 3 of 8 words are loaded -> state_dbg=IDLE and in_ready=0 immediately; a new start reloads from address 0.
REQ-039 num_words=0 -> FSM goes directly to RUN with no mem_wen pulse; a second start asserted while busy has no effect.
